// File: rtl/bus_arb.sv
// bus_arb: round-robin two-master bus arbiter; define BUS_ARB_TIMEOUT_EN to enable the no-ack watchdog.
module bus_arb #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_stb,
  input  logic        m1_stb,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [23:2] m0_addr,
  input  logic [23:2] m1_addr,
  input  logic [31:0] m0_dout,
  input  logic [31:0] m1_dout,
  output logic [31:0] m0_din,
  output logic [31:0] m1_din,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [23:2] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic [1:0]  gnt,
  output logic        tmo
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state;
  logic last;
  logic act, sel, cur_stb, force_ack, done;
  logic [31:0] din;
  assign act = state != IDLE;
  assign sel = state == GNT1;
  assign cur_stb = sel ? m1_stb : m0_stb;
`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign force_ack = act && cur_stb && !bus_ack && cnt == 8'(TIMEOUT - 1);
  // a new grant always starts from IDLE or a completed transfer, so both clear the count
  always_ff @(posedge clk)
    if (rst || !act || done) cnt <= '0;
    else cnt <= cnt + 8'd1;
`else
  assign force_ack = 1'b0;
`endif
  assign done = act && (bus_ack || force_ack);
  assign din = force_ack ? '1 : bus_din;
  assign bus_stb = act && cur_stb;
  assign bus_we = act && (sel ? m1_we : m0_we);
  assign bus_addr = act ? (sel ? m1_addr : m0_addr) : '0;
  assign bus_dout = act ? (sel ? m1_dout : m0_dout) : '0;
  assign m0_ack = state == GNT0 && done;
  assign m1_ack = state == GNT1 && done;
  assign m0_din = state == GNT0 ? din : '0;
  assign m1_din = state == GNT1 ? din : '0;
  assign gnt = {state == GNT1, state == GNT0};
  assign tmo = force_ack;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      last <= 1'b1;
    end else if (!act) begin
      state <= m0_stb && (!m1_stb || last) ? GNT0 : m1_stb ? GNT1 : IDLE;
    end else if (done) begin
      last <= sel;
      state <= (sel ? m0_stb : m1_stb) ? (sel ? GNT0 : GNT1) : IDLE;
    end else if (!cur_stb) begin
      state <= IDLE;
    end
endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: directed checks of arbitration, pass-through, reset abort and watchdog of bus_arb.
module tb_bus_arb;
  logic clk = 0, rst;
  logic m0_stb, m1_stb, m0_we, m1_we, m0_ack, m1_ack;
  logic [23:2] m0_addr, m1_addr, bus_addr;
  logic [31:0] m0_dout, m1_dout, m0_din, m1_din, bus_dout, bus_din;
  logic bus_stb, bus_we, bus_ack, tmo;
  logic [1:0] gnt;
  int errors = 0, checks = 0;
  bus_arb #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m1_stb(m1_stb), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_dout(m0_dout), .m1_dout(m1_dout),
    .m0_din(m0_din), .m1_din(m1_din), .m0_ack(m0_ack), .m1_ack(m1_ack),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_ack(bus_ack), .gnt(gnt), .tmo(tmo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {m0_stb, m1_stb, m0_we, m1_we, bus_ack} = '0;
    {m0_addr, m1_addr, m0_dout, m1_dout, bus_din} = '0;
    rst = 1;
    cyc(); cyc();
    rst = 0;
    #2;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_stb", 32'(bus_stb), 0);
    check("rst_tmo", 32'(tmo), 0);
    check("rst_ack", 32'({m1_ack, m0_ack}), 0);
    // m0 read, slave acks in the third granted cycle
    cyc(); m0_stb = 1; m0_addr = 22'h40; #2;
    check("rd_latency", 32'(bus_stb), 0);
    cyc(); #2;
    check("rd_gnt", 32'(gnt), 32'b01);
    check("rd_stb", 32'(bus_stb), 1);
    check("rd_addr", 32'(bus_addr), 32'h40);
    check("rd_noack", 32'(m0_ack), 0);
    cyc(); cyc(); bus_ack = 1; bus_din = 32'h12345678; #2;
    check("rd_ack", 32'(m0_ack), 1);
    check("rd_din", m0_din, 32'h12345678);
    check("rd_m1din", m1_din, 0);
    check("rd_m1ack", 32'(m1_ack), 0);
    cyc(); m0_stb = 0; bus_ack = 0; #2;
    check("rd_idle_gnt", 32'(gnt), 0);
    check("rd_idle_din", m0_din, 0);
    // reset in second granted cycle of m1 (last is 0 here)
    cyc(); m1_stb = 1; m1_addr = 22'h155;
    cyc(); #2;
    check("ra_gnt1", 32'(gnt), 32'b10);
    cyc(); rst = 1; #2;
    check("ra_gnt2", 32'(gnt), 32'b10);
    cyc(); rst = 0; m0_stb = 1; #2;
    check("ra_stb", 32'(bus_stb), 0);
    check("ra_gnt", 32'(gnt), 0);
    check("ra_noack", 32'(m1_ack), 0);
    // contention after reset: m0 first, then strict alternation
    cyc(); bus_ack = 1; #2;
    check("rr_first", 32'(gnt), 32'b01);
    check("rr_addr0", 32'(bus_addr), 32'h40);
    check("rr_ack0", 32'(m0_ack), 1);
    check("rr_m1quiet", 32'(m1_ack), 0);
    cyc(); bus_ack = 0; #2;
    check("rr_hand1", 32'(gnt), 32'b10);
    check("rr_addr1", 32'(bus_addr), 32'h155);
    check("rr_stb1", 32'(bus_stb), 1);
    cyc(); bus_ack = 1; #2;
    check("rr_ack1", 32'(m1_ack), 1);
    check("rr_m0quiet", 32'(m0_ack), 0);
    cyc(); m1_stb = 0; #2;
    check("rr_hand0", 32'(gnt), 32'b01);
    check("rr_ack0b", 32'(m0_ack), 1);
    check("rr_m1quiet2", 32'(m1_ack), 0);
    cyc(); bus_ack = 0; m0_stb = 0; #2;
    check("rr_idle", 32'(gnt), 0);
    // m1 write
    cyc(); m1_stb = 1; m1_we = 1; m1_addr = 22'h3FFFF1; m1_dout = 32'hDEADBEEF;
    cyc(); #2;
    check("wr_gnt", 32'(gnt), 32'b10);
    check("wr_we", 32'(bus_we), 1);
    check("wr_addr", 32'(bus_addr), 32'h3FFFF1);
    check("wr_dout", bus_dout, 32'hDEADBEEF);
    check("wr_m0ack", 32'(m0_ack), 0);
    cyc(); bus_ack = 1; #2;
    check("wr_ack", 32'(m1_ack), 1);
    check("wr_m0ack2", 32'(m0_ack), 0);
    cyc(); bus_ack = 0; m1_stb = 0; m1_we = 0; #2;
    check("wr_idle_we", 32'(bus_we), 0);
    check("wr_idle_dout", bus_dout, 0);
    // m0 withdraws without ack: IDLE, last stays 1
    cyc(); m0_stb = 1;
    cyc(); #2;
    check("dr_gnt", 32'(gnt), 32'b01);
    cyc(); m0_stb = 0; #2;
    check("dr_stb", 32'(bus_stb), 0);
    cyc(); m0_stb = 1; m1_stb = 1; #2;
    check("dr_idle", 32'(gnt), 0);
    cyc(); bus_ack = 1; #2;
    check("dr_last", 32'(gnt), 32'b01);
    cyc(); m0_stb = 0; #2;
    check("dr_hand", 32'(gnt), 32'b10);
    check("dr_ack1", 32'(m1_ack), 1);
    cyc(); bus_ack = 0; m1_stb = 0; #2;
    check("dr_end", 32'(gnt), 0);
    // unacknowledged transfer
    cyc(); m0_stb = 1;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      cyc(); #2;
      check("to_tmo", 32'(tmo), i == 4 ? 1 : 0);
      check("to_ack", 32'(m0_ack), i == 4 ? 1 : 0);
    end
    check("to_din", m0_din, 32'hFFFFFFFF);
    cyc(); #2;
    check("to_idle", 32'(gnt), 0);
    m0_stb = 0;
`else
    begin
      logic seen_tmo, lost;
      seen_tmo = 0;
      lost = 0;
      for (int i = 0; i < 1000; i++) begin
        cyc(); #2;
        if (tmo) seen_tmo = 1;
        if (gnt != 2'b01 || m0_ack) lost = 1;
      end
      check("nt_tmo", 32'(seen_tmo), 0);
      check("nt_held", 32'(lost), 0);
      check("nt_gnt", 32'(gnt), 32'b01);
    end
    m0_stb = 0;
`endif
    cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_arb.md
# bus_arb

Two-master arbiter for the 16 MB RISC5 system bus. It sits between two bus masters (master 0 = CPU, master 1 = a DMA-capable peripheral) and the address decoder/slave multiplexers. It grants the single shared bus (stb/we/addr/data/ack) to one master per transfer, using round-robin fairness. An optional watchdog terminates transfers that receive no acknowledge.

## Interface
- TIMEOUT, 255: bus cycles a granted transfer may wait for `bus_ack` before forced termination (only with `BUS_ARB_TIMEOUT_EN`); legal range 2..255.
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; synchronous, active-high
- m0_stb, m1_stb  in  1  master request/strobe; held until that master's ack
- m0_we, m1_we  in  1  master write enable
- m0_addr, m1_addr  in  [23:2]  master word address
- m0_dout, m1_dout  in  32  master write data
- m0_din, m1_din  out  32  read data returned to master
- m0_ack, m1_ack  out  1  acknowledge to master
- bus_stb  out  1  strobe to address decoder
- bus_we  out  1  write enable to slaves
- bus_addr  out  [23:2]  address to decoder/slaves
- bus_dout  out  32  write data to slaves
- bus_din  in  32  read data from slave multiplexer
- bus_ack  in  1  acknowledge from slave multiplexer
- gnt  out  2  one-hot current grant, {m1, m0}
- tmo  out  1  one-cycle pulse on forced termination

## Operation
- State register: IDLE, GNT0, GNT1. A `last` register records the last-served master.
- IDLE: `bus_stb`, `bus_we`, `bus_addr`, `bus_dout` are 0. Both acks are 0. Both din are 0.
  - Request only from m0 → GNT0. Request only from m1 → GNT1.
  - Requests from both → grant the master ≠ `last`.
  - No request → stay in IDLE.
- GNTx: bus outputs mirror master x's inputs combinationally. `bus_stb` = `mx_stb`. `mx_din` = `bus_din`. `mx_ack` = `bus_ack`. The other master sees ack=0 and din=0.
- End of transfer, when `bus_ack`=1 in GNTx:
  - `last` ← x.
  - If the other master's stb=1 → go directly to GNT(other); no idle cycle.
  - Otherwise → IDLE.
  - The same master is never re-granted in its own ack cycle, because its stb is still high then.
- Master x drops `mx_stb` while granted, without ack → IDLE. `last` is unchanged.
- `gnt` = 2'b01 in GNT0, 2'b10 in GNT1, 2'b00 in IDLE.
- Reset values (after the reset edge): state IDLE, `last`=1 (so m0 wins the first contention), gnt=0, tmo=0, all bus outputs and both acks 0. Timeout counter = 0.
- Reset mid-transfer: the grant is dropped at the edge. `bus_stb`=0 from the next cycle. No ack is generated for the aborted transfer.

## Timing
- State, `last` and the counter are registered. All bus/master outputs are combinational from the state and the granted master's inputs (zero-latency pass-through once granted).
- Arbitration latency: a request first seen in IDLE at cycle n gives `bus_stb`=1 at cycle n+1.
- Back-to-back alternating transfers: the other master's `bus_stb` appears the cycle after the ack.
- Read data is valid on `mx_din` in the same cycle as `mx_ack`.
- Simultaneous requests arriving in the same cycle are resolved only by `last`; there is no fixed priority.

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter clears on every grant entry and increments each GNTx cycle without `bus_ack`.
  - In a GNTx cycle with counter = TIMEOUT-1 and `bus_ack`=0, the arbiter forces `mx_ack`=1 and `mx_din`=32'hFFFFFFFF, and pulses `tmo`=1.
  - That cycle is then treated exactly as a normal ack: `last` update and handoff/IDLE rules apply.
  - A real `bus_ack` in that same cycle takes precedence: no tmo, slave data is returned.
- Not defined: no counter. `tmo` is tied 0. A transfer waits for `bus_ack` indefinitely.

## Test plan
- m0 read at 0x000100: m0_stb at cycle 0, slave acks at cycle 3 with din=0x12345678 → bus_stb high in cycles 1–3, m0_ack and m0_din=0x12345678 at cycle 3, gnt=01 in cycles 1–3, IDLE at cycle 4.
- m0 and m1 both request at cycle 0 after reset → m0 granted first. m1's bus_stb starts the cycle after m0's ack. Repeating both requests continuously alternates m0, m1, m0, with m1_ack never asserted during m0's grant.
- m1 write 0xDEADBEEF to 0xFFFFC4 → bus_we=1, bus_addr=0x3FFFF1, bus_dout=0xDEADBEEF while granted. m0 sees ack=0 throughout.
- rst asserted in the second granted cycle of an m1 transfer → bus_stb=0 and gnt=00 the next cycle. No m1_ack. After release, the next contention goes to m0.
- With `BUS_ARB_TIMEOUT_EN`, TIMEOUT=4, no slave ack → m0_ack=1, m0_din=0xFFFFFFFF and tmo=1 in the 4th granted cycle, then IDLE. Without the macro, the transfer remains granted for 1000+ cycles with tmo=0.
